mem_stage: RTL and testbench

//  MEM pipeline stage. Consumes the packed EX->MEM bus held by the ex/mem register, executes loads and stores on a
//  req/gnt/rvalid data-memory port, aligns and extends load data, then hands a packed MEM->WB bus to mem/wb.

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid port and forms the MEM->WB bus.
// Optional define MEM_ALIGN_CHK_EN turns misaligned half/word accesses into exceptions instead of requests.
module mem_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5,
  parameter int unsigned EX_W = 3*XLEN+4+RA_W+1,
  parameter int unsigned WB_W = 2*XLEN+RA_W+2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [EX_W-1:0] ex2mem_bus_i,
  input  logic            mem_valid_i,
  input  logic            ctl_wb_allow_in_i,
  output logic            ctl_mem_allow_in_o,
  output logic            ctl_mem_over_o,
  output logic [WB_W-1:0] mem2wb_bus_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_wstrb_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state;
  logic [XLEN-1:0]   in_pc, in_alu, in_st;
  logic [3:0]        in_op;
  logic [RA_W-1:0]   in_rd;
  logic              in_we;
  logic              in_load, in_store, in_mis, accept;
  logic [XLEN-1:0]   r_pc, r_alu;
  logic [3:0]        r_op;
  logic [RA_W-1:0]   r_rd;
  logic              r_we;

  assign {in_pc, in_alu, in_st, in_op, in_rd, in_we} = ex2mem_bus_i;

  function automatic logic [3:0] lane_strb(input logic [3:0] op, input logic [1:0] a);
    case (op)
      4'd9:    return 4'b0001 << a;
      4'd10:   return a[1] ? 4'b1100 : 4'b0011;
      4'd11:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [3:0] op, input logic [XLEN-1:0] st);
    case (op)
      4'd9:    return {(XLEN/8){st[7:0]}};
      4'd10:   return {(XLEN/16){st[15:0]}};
      4'd11:   return st;
      default: return '0;
    endcase
  endfunction

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [XLEN-1:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      4'd1:    return {{(XLEN-8){b[7]}}, b};
      4'd2:    return {{(XLEN-16){h[15]}}, h};
      4'd4:    return {{(XLEN-8){1'b0}}, b};
      4'd5:    return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    in_load  = in_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    in_store = in_op inside {4'd9, 4'd10, 4'd11};
`ifdef MEM_ALIGN_CHK_EN
    in_mis   = ((in_op inside {4'd2, 4'd5, 4'd10}) && in_alu[0]) ||
               ((in_op inside {4'd3, 4'd11}) && (in_alu[1:0] != 2'b00));
`else
    in_mis   = 1'b0;
`endif
    ctl_mem_allow_in_o = (state == IDLE) || ((state == DONE) && ctl_wb_allow_in_i);
    accept             = mem_valid_i && ctl_mem_allow_in_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      ctl_mem_over_o <= 1'b0;
      mem2wb_bus_o   <= '0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_wstrb_o   <= '0;
      dmem_wdata_o   <= '0;
      r_pc           <= '0;
      r_alu          <= '0;
      r_op           <= '0;
      r_rd           <= '0;
      r_we           <= 1'b0;
    end else begin
      case (state)
        REQ: if (dmem_gnt_i) begin
          dmem_req_o <= 1'b0;
          if (r_op inside {4'd9, 4'd10, 4'd11}) begin
            state          <= DONE;
            ctl_mem_over_o <= 1'b1;
            mem2wb_bus_o   <= {r_pc, r_alu, r_rd, r_we, 1'b0};
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dmem_rvalid_i) begin
          state          <= DONE;
          ctl_mem_over_o <= 1'b1;
          mem2wb_bus_o   <= {r_pc, load_ext(r_op, r_alu[1:0], dmem_rdata_i), r_rd, r_we, 1'b0};
        end
        DONE: if (ctl_wb_allow_in_i) begin
          state          <= IDLE;
          ctl_mem_over_o <= 1'b0;
        end
        default: ;
      endcase

      // A new instruction overrides whatever DONE just decided.
      if (accept) begin
        r_pc  <= in_pc;
        r_alu <= in_alu;
        r_op  <= in_op;
        r_rd  <= in_rd;
        r_we  <= in_we && !in_store;
        if (in_mis) begin
          state          <= DONE;
          ctl_mem_over_o <= 1'b1;
          mem2wb_bus_o   <= {in_pc, in_alu, in_rd, 1'b0, 1'b1};
        end else if (in_load || in_store) begin
          state          <= REQ;
          ctl_mem_over_o <= 1'b0;
          dmem_req_o     <= 1'b1;
          dmem_we_o      <= in_store;
          dmem_addr_o    <= {in_alu[XLEN-1:2], 2'b00};
          dmem_wstrb_o   <= lane_strb(in_op, in_alu[1:0]);
          dmem_wdata_o   <= lane_data(in_op, in_st);
        end else begin
          state          <= DONE;
          ctl_mem_over_o <= 1'b1;
          mem2wb_bus_o   <= {in_pc, in_alu, in_rd, in_we, 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random traffic against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [105:0] ex2mem_bus_i;
  logic         mem_valid_i;
  logic         ctl_wb_allow_in_i;
  logic         ctl_mem_allow_in_o;
  logic         ctl_mem_over_o;
  logic [70:0]  mem2wb_bus_o;
  logic         dmem_req_o, dmem_we_o;
  logic [31:0]  dmem_addr_o, dmem_wdata_o;
  logic [3:0]   dmem_wstrb_o;
  logic         dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0]  dmem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .ex2mem_bus_i(ex2mem_bus_i), .mem_valid_i(mem_valid_i),
    .ctl_wb_allow_in_i(ctl_wb_allow_in_i), .ctl_mem_allow_in_o(ctl_mem_allow_in_o),
    .ctl_mem_over_o(ctl_mem_over_o), .mem2wb_bus_o(mem2wb_bus_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory responder: grant after gnt_lat cycles of req, data rv_lat cycles after grant.
  int          gnt_lat = 0, rv_lat = 1, req_cnt = 0, rv_cnt = 0;
  logic [31:0] rv_addr = '0, fix_data = '0;
  bit          rnd = 0, use_fix = 0;

  always @(posedge clk) begin
    #1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = $urandom;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = use_fix ? fix_data : rd_fn(rv_addr);
      end
    end
    if (dmem_req_o) begin
      if (req_cnt >= gnt_lat) begin
        dmem_gnt_i = 1'b1;
        req_cnt    = 0;
        if (!dmem_we_o) begin
          rv_cnt  = rv_lat;
          rv_addr = dmem_addr_o;
        end
        if (rnd) begin
          gnt_lat = $urandom_range(0, 3);
          rv_lat  = $urandom_range(1, 4);
        end
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
    if (rnd) ctl_wb_allow_in_i = ($urandom_range(0, 3) != 0);
  end

  // Transaction-level model of the instruction currently held by the stage.
  bit           armed = 0, rst_chk = 0, m_busy = 0, m_ready = 0, m_reqw = 0, m_rdw = 0, e_store = 0;
  logic [70:0]  e_bus = '0;
  logic [68:0]  e_req = '0;

  task automatic model_accept(input logic [105:0] b);
    logic [31:0] pc, alu, st, word, raw, mask, wd;
    logic [3:0]  op, strb;
    logic [4:0]  rd;
    logic        we;
    int          size, off;
    bit          ld, stv, mis;
    {pc, alu, st, op, rd, we} = b;
    size = (op == 4'd1 || op == 4'd4 || op == 4'd9)  ? 1 :
           (op == 4'd2 || op == 4'd5 || op == 4'd10) ? 2 :
           (op == 4'd3 || op == 4'd11)               ? 4 : 0;
    ld   = (op >= 4'd1 && op <= 4'd5);
    stv  = (op >= 4'd9 && op <= 4'd11);
    mis  = 0;
`ifdef MEM_ALIGN_CHK_EN
    if (size > 0 && (int'(alu[1:0]) % size) != 0) mis = 1;
`endif
    m_busy = 1;
    if (size == 0 || mis) begin
      m_ready = 1;
      e_bus   = {pc, alu, rd, (mis ? 1'b0 : we), mis};
    end else begin
      off  = int'(alu[1:0]) & ~(size - 1);
      strb = '0;
      wd   = '0;
      if (stv)
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + size) strb[i] = 1'b1;
          wd[8*i +: 8] = st[8*(i % size) +: 8];
        end
      e_req   = {stv, alu & 32'hFFFF_FFFC, strb, wd};
      e_store = stv;
      m_reqw  = 1;
      if (stv || !ld) begin
        e_bus = {pc, alu, rd, 1'b0, 1'b0};
      end else begin
        word = use_fix ? fix_data : rd_fn(alu & 32'hFFFF_FFFC);
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*size)) - 32'd1;
        raw  = (word >> (8*off)) & mask;
        if ((op == 4'd1 || op == 4'd2) && raw[8*size-1]) raw = raw | ~mask;
        e_bus = {pc, raw, rd, we, 1'b0};
      end
    end
  endtask

  always @(negedge clk) begin
    bit retire, acc;
    if (armed) begin
      if (rst_chk) begin
        chk("rst_ctl", 128'({ctl_mem_over_o, dmem_req_o, dmem_we_o, dmem_wstrb_o}), 128'(0));
        chk("rst_data", 128'({dmem_addr_o, dmem_wdata_o}), 128'(0));
        chk("rst_bus", 128'(mem2wb_bus_o), 128'(0));
        rst_chk = 0;
      end
      chk("over", 128'(ctl_mem_over_o), 128'(m_ready));
      if (m_ready) chk("wb_bus", 128'(mem2wb_bus_o), 128'(e_bus));
      chk("req", 128'(dmem_req_o), 128'(m_reqw));
      if (m_reqw)
        chk("req_fields", 128'({dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o}), 128'(e_req));
      chk("allow_in", 128'(ctl_mem_allow_in_o), 128'(!m_busy || (m_ready && ctl_wb_allow_in_i)));
    end
    if (!rst_i) begin
      armed = 1; rst_chk = 1;
      m_busy = 0; m_ready = 0; m_reqw = 0; m_rdw = 0;
    end else if (armed) begin
      retire = m_ready && ctl_wb_allow_in_i;
      acc    = mem_valid_i && (!m_busy || retire);
      if (retire) begin m_ready = 0; m_busy = 0; end
      if (m_rdw && dmem_rvalid_i) begin m_rdw = 0; m_ready = 1; end
      if (m_reqw && dmem_gnt_i) begin
        m_reqw = 0;
        if (e_store) m_ready = 1; else m_rdw = 1;
      end
      if (acc) model_accept(ex2mem_bus_i);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] st,
                       input logic [31:0] pc, input logic [4:0] rd, input logic we);
    int n = 0;
    #1;
    while (!ctl_mem_allow_in_o && n < 64) begin @(posedge clk); #2; n++; end
    if (!ctl_mem_allow_in_o) chk("issue_timeout", 128'(ctl_mem_allow_in_o), 128'(1));
    else begin
      ex2mem_bus_i = {pc, a, st, op, rd, we};
      mem_valid_i  = 1'b1;
    end
    @(posedge clk); #1;
    mem_valid_i  = 1'b0;
    ex2mem_bus_i = 106'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_over(output int n);
    n = 0;
    while (!ctl_mem_over_o && n < 64) begin step(); n++; end
    chk("over_timeout", 128'(ctl_mem_over_o), 128'(1));
  endtask

  logic [3:0]  ld_op  [4] = '{4'd1, 4'd1, 4'd4, 4'd2};
  logic [31:0] ld_a   [4] = '{32'h1000, 32'h1001, 32'h1001, 32'h1000};
  logic [31:0] ld_exp [4] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000};
  logic [3:0]  r_ops  [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7, 4'd13};

  initial begin
    int n;
    rst_i = 1'b0; mem_valid_i = 1'b0; ex2mem_bus_i = '0; ctl_wb_allow_in_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    chk("reset_over", 128'(ctl_mem_over_o), 128'(0));
    chk("reset_allow", 128'(ctl_mem_allow_in_o), 128'(1));

    use_fix = 1; fix_data = 32'hDEAD_BEEF; gnt_lat = 2; rv_lat = 3;
    issue(4'd3, 32'h1000, 32'h0, 32'h100, 5'd3, 1'b1);
    wait_over(n);
    chk("lw_latency", 128'(n), 128'(6));
    chk("lw_data", 128'(mem2wb_bus_o[38:7]), 128'(32'hDEAD_BEEF));

    gnt_lat = 1;
    issue(4'd9, 32'h1003, 32'h12AB, 32'h104, 5'd7, 1'b1);
    chk("sb_req", 128'({dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o}),
        128'({1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB}));
    wait_over(n);
    chk("sb_rfwe", 128'(mem2wb_bus_o[1]), 128'(0));
    chk("sb_wb", 128'(mem2wb_bus_o[38:7]), 128'(32'h1003));
    issue(4'd10, 32'h1002, 32'h12AB, 32'h108, 5'd7, 1'b1);
    chk("sh_req", 128'({dmem_wstrb_o, dmem_wdata_o}), 128'({4'b1100, 32'h12AB_12AB}));
    wait_over(n);

    fix_data = 32'h0000_8000; gnt_lat = 0; rv_lat = 1;
    for (int i = 0; i < 4; i++) begin
      issue(ld_op[i], ld_a[i], 32'h0, 32'h10C, 5'd1, 1'b1);
      wait_over(n);
      chk("load_ext", 128'(mem2wb_bus_o[38:7]), 128'(ld_exp[i]));
    end
    step();

    ctl_wb_allow_in_i = 1'b0;
    issue(4'd0, 32'h55, 32'h0, 32'h200, 5'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_over", 128'(ctl_mem_over_o), 128'(1));
      chk("hold_allow", 128'(ctl_mem_allow_in_o), 128'(0));
      chk("hold_data", 128'(mem2wb_bus_o[38:7]), 128'(32'h55));
      step();
    end
    ctl_wb_allow_in_i = 1'b1;
    issue(4'd0, 32'h66, 32'h0, 32'h204, 5'd9, 1'b1);
    chk("b2b_over", 128'(ctl_mem_over_o), 128'(1));
    chk("b2b_bus", 128'(mem2wb_bus_o[70:7]), 128'({32'h204, 32'h66}));
    step();

    fix_data = 32'h1111_1111; gnt_lat = 0; rv_lat = 3;
    issue(4'd3, 32'h2000, 32'h0, 32'h300, 5'd4, 1'b1);
    step();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    chk("wait_rst_outs", 128'({ctl_mem_over_o, dmem_req_o, mem2wb_bus_o}), 128'(0));
    chk("wait_rst_allow", 128'(ctl_mem_allow_in_o), 128'(1));
    repeat (4) step();
    chk("late_rvalid_ignored", 128'(ctl_mem_over_o), 128'(0));
    fix_data = 32'h2222_2222; rv_lat = 1;
    issue(4'd3, 32'h2004, 32'h0, 32'h304, 5'd4, 1'b1);
    wait_over(n);
    chk("post_rst_lw", 128'(mem2wb_bus_o[38:7]), 128'(32'h2222_2222));

`ifdef MEM_ALIGN_CHK_EN
    issue(4'd3, 32'h1002, 32'h0, 32'h400, 5'd6, 1'b1);
    chk("mis_req", 128'(dmem_req_o), 128'(0));
    chk("mis_over", 128'(ctl_mem_over_o), 128'(1));
    chk("mis_exc_we", 128'(mem2wb_bus_o[1:0]), 128'(2'b01));
    chk("mis_wb", 128'(mem2wb_bus_o[38:7]), 128'(32'h1002));
`else
    fix_data = 32'hCAFE_F00D;
    issue(4'd3, 32'h1002, 32'h0, 32'h400, 5'd6, 1'b1);
    chk("noalign_addr", 128'(dmem_addr_o), 128'(32'h1000));
    wait_over(n);
    chk("noalign_data", 128'(mem2wb_bus_o[38:7]), 128'(32'hCAFE_F00D));
    chk("noalign_exc", 128'(mem2wb_bus_o[0]), 128'(0));
`endif

    use_fix = 0; rnd = 1;
    repeat (300) begin
      issue(r_ops[$urandom_range(0, 10)], 32'h4000 | 32'($urandom_range(0, 255)), $urandom,
            $urandom, 5'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd = 0;
    ctl_wb_allow_in_i = 1'b1;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
